// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-address qualification helper used by the
// register file and its read ports.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  // An address names a real, writable register only if it is in range and is not the
  // hardwired zero register.
  function automatic logic addr_valid(input int unsigned addr, input int unsigned num_regs,
                                      input logic zero_reg);
    return (addr < num_regs) && (!zero_reg || addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: bypass mux, zero/range masking and busy qualification.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_stored,
  input  logic              i_pending,
  input  logic              i_wr0_en,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  input  logic              i_wr1_en,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  logic w_valid, w_hit0, w_hit1;

  // A valid read address implies a matching write address is valid too, so the raw
  // enables are safe to use for the bypass.
  always_comb begin
    w_valid = !i_reset && addr_valid(32'(i_addr), NUM_REGS, ZERO_REG != 0);
    w_hit0  = (BYPASS != 0) && i_wr0_en && (i_wr0_addr == i_addr);
    w_hit1  = (BYPASS != 0) && i_wr1_en && (i_wr1_addr == i_addr);
    o_data  = '0;
    o_busy  = 1'b0;
    if (w_valid) begin
      if (w_hit1)      o_data = i_wr1_data;
      else if (w_hit0) o_data = i_wr0_data;
      else             o_data = i_stored;
      o_busy = i_pending && !(w_hit0 || w_hit1);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write ports
// and a per-register pending scoreboard for the hazard unit.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr0_en,
  input  logic [ADDR_W-1:0]        i_wr0_addr,
  input  logic [DATA_W-1:0]        i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [ADDR_W-1:0]        i_wr1_addr,
  input  logic [DATA_W-1:0]        i_wr1_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  output logic                     o_busy_any
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  logic                r_busy_any;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic                w_wr0_ok, w_wr1_ok, w_rsv_ok;

  assign w_wr0_ok = i_wr0_en && addr_valid(32'(i_wr0_addr), NUM_REGS, ZERO_REG != 0);
  assign w_wr1_ok = i_wr1_en && addr_valid(32'(i_wr1_addr), NUM_REGS, ZERO_REG != 0);
  assign w_rsv_ok = i_rsv_en && addr_valid(32'(i_rsv_addr), NUM_REGS, ZERO_REG != 0);

  // Set after clear: a younger producer re-reserving wins over the older writeback.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((w_wr0_ok && i_wr0_addr == ADDR_W'(i)) || (w_wr1_ok && i_wr1_addr == ADDR_W'(i)))
        w_pend_nxt[i] = 1'b0;
      if (w_rsv_ok && i_rsv_addr == ADDR_W'(i))
        w_pend_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_pend     <= '0;
      r_busy_any <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr1_ok && i_wr1_addr == ADDR_W'(i))      r_regs[i] <= i_wr1_data;
        else if (w_wr0_ok && i_wr0_addr == ADDR_W'(i)) r_regs[i] <= i_wr0_data;
      end
      r_pend     <= w_pend_nxt;
      r_busy_any <= |w_pend_nxt;
    end
  end

  assign o_busy_any = r_busy_any;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_stored;
    logic              w_pend;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    // Explicit select loop keeps out-of-range addresses from indexing past the array.
    always_comb begin
      w_stored = '0;
      w_pend   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_addr == ADDR_W'(i)) begin
          w_stored = r_regs[i];
          w_pend   = r_pend[i];
        end
      end
    end

    regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
      .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .i_reset   (i_reset),
      .i_addr    (w_addr),
      .i_stored  (w_stored),
      .i_pending (w_pend),
      .i_wr0_en  (i_wr0_en),
      .i_wr0_addr(i_wr0_addr),
      .i_wr0_data(i_wr0_data),
      .i_wr1_en  (i_wr1_en),
      .i_wr1_addr(i_wr1_addr),
      .i_wr1_data(i_wr1_data),
      .o_data    (o_rd_data[k*DATA_W +: DATA_W]),
      .o_busy    (o_rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register-file configurations share one random stimulus stream
// and are checked against an array-based reference model.
module tb_regfile_mp;

  localparam int NRD = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rd_addr;
  logic        wr0_en, wr1_en, rsv_en;
  logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;

  logic [95:0] data_a, data_b;
  logic [2:0]  busy_a, busy_b;
  logic        any_a, any_b;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr), .o_rd_data(data_a), .o_rd_busy(busy_a),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy_any(any_a)
  );

  regfile_mp #(.NUM_REGS(16), .BYPASS(0)) u_b (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr), .o_rd_data(data_b), .o_rd_busy(busy_b),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy_any(any_b)
  );

  typedef struct packed {
    logic [1:0][95:0] data;
    logic [1:0][2:0]  busy;
    logic [1:0]       any;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: one architectural state per configuration (0 = A, 1 = B).
  int unsigned m_reg  [2][32];
  bit          m_pend [2][32];
  int          nregs  [2] = '{32, 16};
  bit          byp    [2] = '{1'b1, 1'b0};

  function automatic bit ok(int c, int a);
    return (a < nregs[c]) && (a != 0);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_reg[c][i]  = 0;
        m_pend[c][i] = 0;
      end
  endtask

  // Expected outputs for the cycle just driven, then the state after the next edge.
  task automatic go();
    exp_t e;
    e = '0;
    if (reset) model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) if (m_pend[c][i]) e.any[c] = 1'b1;
      for (int k = 0; k < NRD; k++) begin
        int          a;
        int unsigned d;
        bit          wh;
        a  = int'(rd_addr[k*5 +: 5]);
        d  = 0;
        wh = byp[c] && ((wr0_en && wr0_addr == a[4:0]) || (wr1_en && wr1_addr == a[4:0]));
        if (!reset && ok(c, a)) begin
          if (byp[c] && wr1_en && wr1_addr == a[4:0])      d = wr1_data;
          else if (byp[c] && wr0_en && wr0_addr == a[4:0]) d = wr0_data;
          else                                             d = m_reg[c][a];
          e.busy[c][k] = m_pend[c][a] && !wh;
        end
        e.data[c][k*32 +: 32] = d;
      end
    end
    q.push_back(e);
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        if (wr0_en && ok(c, int'(wr0_addr))) begin
          m_reg[c][wr0_addr] = wr0_data; m_pend[c][wr0_addr] = 0;
        end
        if (wr1_en && ok(c, int'(wr1_addr))) begin
          m_reg[c][wr1_addr] = wr1_data; m_pend[c][wr1_addr] = 0;
        end
        if (rsv_en && ok(c, int'(rsv_addr))) m_pend[c][rsv_addr] = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so the DUT presents a result every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("A.rd_data",  data_a,        e.data[0]);
        chk("A.rd_busy",  96'(busy_a),   96'(e.busy[0]));
        chk("A.busy_any", 96'(any_a),    96'(e.any[0]));
        chk("B.rd_data",  data_b,        e.data[1]);
        chk("B.rd_busy",  96'(busy_b),   96'(e.busy[1]));
        chk("B.busy_any", 96'(any_b),    96'(e.any[1]));
      end
    end
  end

  task automatic nx();
    @(negedge clk);
    reset = 1'b0; rd_addr = '0;
    wr0_en = 0; wr1_en = 0; rsv_en = 0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
  endfunction

  initial begin
    reset = 1'b1; rd_addr = '0;
    wr0_en = 0; wr1_en = 0; rsv_en = 0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0;
    model_clear();

    nx(); reset = 1; go();
    nx(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; go();
    nx(); rd_addr[4:0] = 5; go();
    nx(); reset = 1; rd_addr[4:0] = 5; wr0_en = 1; wr0_addr = 6; wr0_data = 32'h77;
          rsv_en = 1; rsv_addr = 6; go();
    nx(); rd_addr[4:0] = 5; rd_addr[9:5] = 6; go();
    nx(); wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11111111;
          wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22222222; rd_addr[4:0] = 3; go();
    nx(); rd_addr[4:0] = 3; go();
    nx(); wr0_en = 1; wr0_addr = 7; wr0_data = 32'hA5A5A5A5; rd_addr[4:0] = 7; go();
    nx(); rd_addr[4:0] = 7; go();
    nx(); wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0; go();
    nx(); go();
    nx(); wr0_en = 1; wr0_addr = 20; wr0_data = 32'h1; rd_addr[4:0] = 20; go();
    nx(); rd_addr[4:0] = 20; go();
    nx(); rsv_en = 1; rsv_addr = 9; rd_addr[9:5] = 9; go();
    nx(); rd_addr[9:5] = 9; go();
    nx(); wr1_en = 1; wr1_addr = 9; wr1_data = 32'h42; rd_addr[9:5] = 9; go();
    nx(); rd_addr[9:5] = 9; go();
    nx(); rsv_en = 1; rsv_addr = 4; wr0_en = 1; wr0_addr = 4; wr0_data = 32'hABC;
          rd_addr[14:10] = 4; go();
    nx(); rd_addr[14:10] = 4; go();
    nx(); reset = 1; rd_addr[14:10] = 4; go();
    nx(); rd_addr[14:10] = 4; go();

    repeat (600) begin
      nx();
      reset    = ($urandom_range(0, 59) == 0);
      rd_addr  = {raddr(), raddr(), raddr()};
      wr0_en   = $urandom_range(0, 1) == 1; wr0_addr = raddr(); wr0_data = $urandom;
      wr1_en   = $urandom_range(0, 2) == 0; wr1_addr = raddr(); wr1_data = $urandom;
      rsv_en   = $urandom_range(0, 2) == 0; rsv_addr = raddr();
      if ($urandom_range(0, 3) == 0) wr1_addr = wr0_addr;
      if ($urandom_range(0, 3) == 0) rsv_addr = wr0_addr;
      go();
    end

    nx(); nx();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: actual=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
